freepdk45_sram_arb_2p_64x40: RTL
================================

// Module: freepdk45_sram_arb_2p_64x40
// PURPOSE
// - Two-requester round-robin arbiter/sequencer for one 1RW OpenRAM macro
//   (freepdk45_sram_1rw0r_64x40_20): shares the single RW port between
//   requesters A and B.
// - Converts valid/ready requests into registered macro controls and returns
//   read data to the requester that issued the read, pipelined at one access
//   per cycle.
// PARAMETERS
// - ADDR_WIDTH  6   word address width (64 words)
// - DATA_WIDTH  40  word width
// - NUM_WMASKS  2   write-mask lanes, DATA_WIDTH/NUM_WMASKS = 20 bits each
// PORTS
// - clk0      in   1            single clock, also drives macro clk0
// - rstb      in   1            reset, synchronous, active-low
// - a_valid   in   1            A request valid
// - a_ready   out  1            A request accepted this cycle (combinational)
// - a_web     in   1            A: 0 = write, 1 = read
// - a_wmask   in   NUM_WMASKS   A write lane enables
// - a_addr    in   ADDR_WIDTH   A word address
// - a_din     in   DATA_WIDTH   A write data
// - a_rvalid  out  1            A read response valid, 1-cycle pulse
// - a_rdata   out  DATA_WIDTH   A read data, valid only while a_rvalid = 1
// - b_*       (same set as a_*)  requester B
// - csb0      out  1            macro chip select, active-low, registered
// - web0      out  1            macro write enable, active-low, registered
// - wmask0    out  NUM_WMASKS   macro write mask, registered
// - addr0     out  ADDR_WIDTH   macro address, registered
// - din0      out  DATA_WIDTH   macro write data, registered
// - dout0     in   DATA_WIDTH   macro read data
// BEHAVIOUR
// - Reset (rstb = 0 at posedge): csb0 = 1, web0 = 1, wmask0 = 0, addr0 = 0,
//   din0 = 0, a_rvalid = b_rvalid = 0, a_rdata = b_rdata = 0. In-flight reads
//   are dropped. RR pointer = A.
// - While rstb = 0: a_ready = b_ready = 0.
// - Arbitration (combinational, each cycle):
//   - Only one valid requester: that requester is granted.
//   - Both valid: the requester named by the RR pointer is granted.
//   - ready = grant. No other stall sources exist.
// - RR pointer: after a cycle in which both are valid, it moves to the
//   requester not granted. Otherwise it is unchanged. No requester waits
//   more than 1 cycle.
// - Accept at posedge N (valid & ready): controls are registered at N.
//   - web0 and addr0 take the granted requester's values.
//   - wmask0 and din0 take the granted requester's values on writes.
//   - On reads, wmask0 and din0 hold their previous values.
//   - csb0 = 0 for exactly that cycle.
// - No accept in a cycle: csb0 = 1 at the next posedge; other controls hold.
// - Write with wmask = 0: accepted (ready = 1) but squashed. csb0 stays 1.
// - Read latency: the macro samples at N+1 and drives dout0 after the negedge
//   of cycle N+1. dout0 is captured at posedge N+2; rvalid pulses high for
//   cycle N+2 to N+3 with rdata.
//   - Source tracking: 2-stage shift of {valid_read, id}.
//   - Captured data goes only to the issuing port. Other port rdata holds.
// - Back-to-back accesses:
//   - One access per cycle; reads fully pipelined, any R/W mix allowed.
//   - Read after write to the same address, issued on the next cycle,
//     returns the new data: the macro writes on the negedge before it reads.
// - Writes produce no response.
// - No response back-pressure: the requester must sink rvalid.
// - Reset mid-operation: pending rvalid is suppressed. A write already in the
//   macro may complete; this is not guaranteed.
// TESTING
// - Reset: hold rstb = 0 for 3 cycles with a_valid = b_valid = 1
//   -> ready = 0, csb0 = 1, rvalid = 0.
// - A write addr 5, din 40'hAB_CDE1_2345, mask 2'b11; next cycle A read addr 5
//   -> a_rvalid exactly 2 cycles after the read accept, a_rdata = 40'hAB_CDE1_2345.
// - A write addr 5, din 0, mask 2'b01, then read addr 5
//   -> a_rdata = 40'hAB_CDE0_0000 (upper lane kept).
// - A and B both valid continuously; A reads addr 1, B reads addr 2
//   -> grants A, B, A, B; a_rdata = mem[1], b_rdata = mem[2]; no cross-routing.
// - A write with mask 2'b00 -> a_ready = 1, csb0 stays 1, memory unchanged.
// - B read accepted, rstb = 0 on the next posedge
//   -> b_rvalid never asserts; csb0 = 1.

Source files
------------

// File: rtl/freepdk45_sram_arb_2p_64x40.sv
// ============================================================================
// Module   : freepdk45_sram_arb_2p_64x40
// Purpose  : Round-robin arbiter for two requesters sharing one 1RW SRAM port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module freepdk45_sram_arb_2p_64x40 #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 40,
    parameter int NUM_WMASKS = 2
) (
    input  logic                  clk0,
    input  logic                  rstb,
    // requester A
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic                  a_web,
    input  logic [NUM_WMASKS-1:0] a_wmask,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    // requester B
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic                  b_web,
    input  logic [NUM_WMASKS-1:0] b_wmask,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    // SRAM macro port
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    typedef enum logic [0:0] {
        RR_A = 1'b0,
        RR_B = 1'b1
    } rr_e;

    rr_e                  rr_q, rr_d;
    logic                 gnt_a, gnt_b, acc, sel_id, sel_web, squash, issue;
    logic [NUM_WMASKS-1:0] sel_wmask;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_din;

    logic                  csb0_q, web0_q;
    logic [NUM_WMASKS-1:0] wmask0_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [DATA_WIDTH-1:0] din0_q;
    logic [1:0]            rd_vld_q, rd_id_q;
    logic                  a_rvalid_q, b_rvalid_q;
    logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;

    always_comb begin
        gnt_a     = rstb & a_valid & (~b_valid | (rr_q == RR_A));
        gnt_b     = rstb & b_valid & (~a_valid | (rr_q == RR_B));
        acc       = gnt_a | gnt_b;
        sel_id    = gnt_b;
        sel_web   = sel_id ? b_web   : a_web;
        sel_wmask = sel_id ? b_wmask : a_wmask;
        sel_addr  = sel_id ? b_addr  : a_addr;
        sel_din   = sel_id ? b_din   : a_din;
        // A write with no enabled lanes is accepted but never reaches the macro.
        squash    = ~sel_web & (sel_wmask == '0);
        issue     = acc & ~squash;
        rr_d      = rr_q;
        if (a_valid & b_valid) begin
            rr_d = gnt_a ? RR_B : RR_A;
        end
    end

    always_ff @(posedge clk0) begin
        if (!rstb) begin
            rr_q       <= RR_A;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
            rd_vld_q   <= '0;
            rd_id_q    <= '0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            rr_q   <= rr_d;
            csb0_q <= ~issue;
            if (issue) begin
                web0_q  <= sel_web;
                addr0_q <= sel_addr;
                if (!sel_web) begin
                    wmask0_q <= sel_wmask;
                    din0_q   <= sel_din;
                end
            end
            // Two stages cover macro sampling at N+1 and data capture at N+2.
            rd_vld_q   <= {rd_vld_q[0], issue & sel_web};
            rd_id_q    <= {rd_id_q[0], sel_id};
            a_rvalid_q <= rd_vld_q[1] & ~rd_id_q[1];
            b_rvalid_q <= rd_vld_q[1] &  rd_id_q[1];
            if (rd_vld_q[1] & ~rd_id_q[1]) begin
                a_rdata_q <= dout0;
            end
            if (rd_vld_q[1] & rd_id_q[1]) begin
                b_rdata_q <= dout0;
            end
        end
    end

    assign a_ready  = gnt_a;
    assign b_ready  = gnt_b;
    assign csb0     = csb0_q;
    assign web0     = web0_q;
    assign wmask0   = wmask0_q;
    assign addr0    = addr0_q;
    assign din0     = din0_q;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

`default_nettype wire
